// File: rtl/txfifo_wr_arb.sv
// Frame-granular round-robin write arbiter for the TX FIFO: a frame is granted only
// when it fits entirely, so frames never interleave and the FIFO never overflows.

module txfifo_wr_arb_elig #(
  parameter int DEPTH = 1024,
  parameter int PTR   = 10,
  parameter int LEN_W = 11
) (
  input  logic             req,
  input  logic [LEN_W-1:0] len,
  input  logic [PTR:0]     free,
  output logic             elig,
  output logic             bad
);
  // Bad lengths are granted regardless of space; they are flushed, never written.
  assign bad  = (len == '0) || (int'(len) > DEPTH);
  assign elig = req && (bad || (int'(len) <= int'(free)));
endmodule

module txfifo_wr_arb #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int PTR   = 10,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             vld0,
  input  logic             vld1,
  input  logic             last0,
  input  logic             last1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rdy0,
  output logic             rdy1,
  output logic             wrreq,
  output logic [WIDTH-1:0] data,
  input  logic [PTR:0]     wrusedw,
  input  logic             wrfull,
  output logic             busy,
  output logic             cur_src,
  output logic             err_len,
  output logic [15:0]      frame_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN} state_t;

  localparam logic [PTR:0] DEPTH_L = (PTR+1)'(DEPTH);

  logic [1:0]                   req_v, vld_v, last_v, elig_v, bad_v, rdy_v;
  logic [1:0][LEN_W-1:0]        len_v;
  logic [1:0][WIDTH-1:0]        data_v;
  logic [PTR:0]                 free;

  state_t           state_q, state_d;
  logic             pref_q, pref_d;
  logic             cur_src_q, cur_src_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic             err_seen_q, err_seen_d;
  logic             drn_q, drn_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             err_q, err_d;
  logic             wrreq_q, wrreq_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             pick, acc, in_len;
  logic [LEN_W-1:0] cnt_inc;

  assign req_v  = {req1, req0};
  assign vld_v  = {vld1, vld0};
  assign last_v = {last1, last0};
  assign len_v  = {len1, len0};
  assign data_v = {data1, data0};
  assign free   = DEPTH_L - wrusedw;

  for (genvar i = 0; i < 2; i++) begin : g_elig
    txfifo_wr_arb_elig #(.DEPTH(DEPTH), .PTR(PTR), .LEN_W(LEN_W)) u_elig (
      .req  (req_v[i]),
      .len  (len_v[i]),
      .free (free),
      .elig (elig_v[i]),
      .bad  (bad_v[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    pref_d      = pref_q;
    cur_src_d   = cur_src_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    err_seen_d  = err_seen_q;
    drn_d       = drn_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = data_q;
    gnt_d       = '0;
    err_d       = 1'b0;
    wrreq_d     = 1'b0;
    rdy_v       = '0;
    pick        = req_v[pref_q] ? pref_q : ~pref_q;
    acc         = 1'b0;
    // cnt_q never passes len_q, so the increment below cannot wrap.
    in_len      = cnt_q < len_q;
    cnt_inc     = cnt_q + LEN_W'(1);

    unique case (state_q)
      S_IDLE: begin
        // No bypass: an ineligible pick blocks the other requester too.
        if (elig_v[pick]) begin
          state_d     = S_XFER;
          cur_src_d   = pick;
          len_d       = len_v[pick];
          bad_d       = bad_v[pick];
          cnt_d       = '0;
          err_seen_d  = bad_v[pick];
          err_d       = bad_v[pick];
          gnt_d[pick] = 1'b1;
          pref_d      = ~pick;
        end
      end
      S_XFER: begin
        rdy_v[cur_src_q] = ~wrfull;
        acc = vld_v[cur_src_q] & ~wrfull;
        if (acc) begin
          if (in_len) begin
            cnt_d = cnt_inc;
            if (!bad_q) begin
              wrreq_d = 1'b1;
              data_d  = data_v[cur_src_q];
            end
          end
          if (!bad_q && !err_seen_q &&
              (!in_len || (last_v[cur_src_q] && cnt_inc < len_q))) begin
            err_d      = 1'b1;
            err_seen_d = 1'b1;
          end
          if (last_v[cur_src_q]) begin
            state_d     = S_DRAIN;
            drn_d       = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        // Two idle cycles let the last write land and wrusedw catch up.
        drn_d = ~drn_q;
        if (drn_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= S_IDLE;
      pref_q      <= 1'b0;
      cur_src_q   <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      err_seen_q  <= 1'b0;
      drn_q       <= 1'b0;
      gnt_q       <= '0;
      err_q       <= 1'b0;
      wrreq_q     <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pref_q      <= pref_d;
      cur_src_q   <= cur_src_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      err_seen_q  <= err_seen_d;
      drn_q       <= drn_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      wrreq_q     <= wrreq_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign rdy0      = rdy_v[0];
  assign rdy1      = rdy_v[1];
  assign wrreq     = wrreq_q;
  assign data      = data_q;
  assign busy      = state_q != S_IDLE;
  assign cur_src   = cur_src_q;
  assign err_len   = err_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_txfifo_wr_arb.sv
// Directed bench for txfifo_wr_arb: expected grants, FIFO writes and length errors
// are queued as frames are issued; a negedge monitor pops and compares.

module tb_txfifo_wr_arb;
  localparam int WIDTH = 64;
  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             aclr = 1'b1;
  logic             req0 = 0, req1 = 0, vld0 = 0, vld1 = 0, last0 = 0, last1 = 0;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic [10:0]      wrusedw = '0;
  logic             wrfull = 1'b0;
  logic             gnt0, gnt1, rdy0, rdy1, wrreq, busy, cur_src, err_len;
  logic [WIDTH-1:0] data;
  logic [15:0]      frame_cnt;

  txfifo_wr_arb dut (
    .clk(clk), .aclr(aclr),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .vld0(vld0), .vld1(vld1),
    .last0(last0), .last1(last1), .gnt0(gnt0), .gnt1(gnt1),
    .rdy0(rdy0), .rdy1(rdy1), .wrreq(wrreq), .data(data),
    .wrusedw(wrusedw), .wrfull(wrfull), .busy(busy), .cur_src(cur_src),
    .err_len(err_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail = 0;
  int               exp_gnt[$];
  int               exp_err[$];
  logic [WIDTH-1:0] exp_wr[$];

  function automatic logic [WIDTH-1:0] word(input logic [WIDTH-1:0] base, input int k);
    return base + 64'(k + 1) * 64'h11;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model of what one frame should produce at the FIFO side.
  task automatic exp_frame(input int src, input int ln, input int nw, input logic [WIDTH-1:0] base);
    exp_gnt.push_back(src);
    if (ln >= 1 && ln <= 1024)
      for (int k = 0; k < nw && k < ln; k++) exp_wr.push_back(word(base, k));
    if (ln < 1 || ln > 1024 || nw != ln) exp_err.push_back(src);
  endtask

  task automatic wait_gnt(input int src, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((src == 0) ? gnt0 : gnt1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_timeout src%0d: no gnt in 300 cycles, expected one", src);
    end
  endtask

  task automatic send_frame(input int src, input int ln, input int nw, input logic [WIDTH-1:0] base);
    bit ok;
    int k, guard;
    if (src == 0) begin len0 = LEN_W'(ln); req0 = 1'b1; end
    else          begin len1 = LEN_W'(ln); req1 = 1'b1; end
    wait_gnt(src, ok);
    if (src == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!ok) return;
    k = 0;
    guard = 0;
    while (k < nw && guard < 400) begin
      if (src == 0) begin vld0 = 1'b1; data0 = word(base, k); last0 = (k == nw - 1); end
      else          begin vld1 = 1'b1; data1 = word(base, k); last1 = (k == nw - 1); end
      if ((src == 0) ? rdy0 : rdy1) k++;
      guard++;
      @(negedge clk);
    end
    if (src == 0) begin vld0 = 1'b0; last0 = 1'b0; end
    else          begin vld1 = 1'b0; last1 = 1'b0; end
    if (k < nw) chk("word_stall", 64'(k), 64'(nw));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {62'd0, gnt1, gnt0}, 64'd0);
    chk({tag, "_rdy"}, {62'd0, rdy1, rdy0}, 64'd0);
    chk({tag, "_wrreq"}, 64'(wrreq), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err_len), 64'd0);
    chk({tag, "_data"}, data, 64'd0);
    chk({tag, "_cur_src"}, 64'(cur_src), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  initial begin
    bit ok;
    int stuck;

    // Scoreboard monitor: runs for the whole test.
    fork
      forever begin
        @(negedge clk);
        if (gnt0 || gnt1) begin
          n_checks++;
          if (exp_gnt.size() == 0) begin
            n_fail++;
            $display("FAIL gnt: unexpected gnt0=%0b gnt1=%0b, expected none", gnt0, gnt1);
          end else begin
            int e;
            e = exp_gnt.pop_front();
            if ((gnt0 && gnt1) || (gnt1 != (e == 1)) || (cur_src != (e == 1))) begin
              n_fail++;
              $display("FAIL gnt: got gnt0=%0b gnt1=%0b cur_src=%0b, expected src%0d", gnt0, gnt1, cur_src, e);
            end
          end
        end
        if (wrreq) begin
          n_checks++;
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL wr: unexpected write %0h, expected none", data);
          end else begin
            logic [WIDTH-1:0] w;
            w = exp_wr.pop_front();
            if (data !== w) begin
              n_fail++;
              $display("FAIL wr: got %0h, expected %0h", data, w);
            end
          end
        end
        if (err_len) begin
          n_checks++;
          if (exp_err.size() == 0) begin
            n_fail++;
            $display("FAIL err_len: unexpected pulse, expected none");
          end else begin
            int e;
            e = exp_err.pop_front();
            if (cur_src != (e == 1)) begin
              n_fail++;
              $display("FAIL err_len: cur_src=%0b, expected src%0d", cur_src, e);
            end
          end
        end
      end
    join_none

    // Reset state
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    aclr = 1'b0;

    // Basic 4-word frame, busy drops 2 cycles after last
    exp_frame(0, 4, 4, 64'd0);
    send_frame(0, 4, 4, 64'd0);
    chk("t1_busy_drain1", 64'(busy), 64'd1);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    @(negedge clk);
    chk("t1_busy_drain2", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // Alternation with both requesters; reset first so src0 is preferred
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    exp_frame(0, 2, 2, 64'hA000);
    exp_frame(1, 2, 2, 64'hB000);
    exp_frame(0, 2, 2, 64'hC000);
    exp_frame(1, 2, 2, 64'hD000);
    fork
      begin send_frame(0, 2, 2, 64'hA000); send_frame(0, 2, 2, 64'hC000); end
      begin send_frame(1, 2, 2, 64'hB000); send_frame(1, 2, 2, 64'hD000); end
    join
    wait_idle();

    // Free-space wait with no bypass
    exp_frame(0, 1, 1, 64'hE000);
    send_frame(0, 1, 1, 64'hE000);
    wrusedw = 11'd1020;
    exp_frame(1, 8, 8, 64'hF000);
    exp_frame(0, 1, 1, 64'h1_0000);
    fork
      send_frame(1, 8, 8, 64'hF000);
      send_frame(0, 1, 1, 64'h1_0000);
      begin
        repeat (2) @(negedge clk);
        stuck = 0;
        for (int i = 0; i < 15; i++) begin
          @(negedge clk);
          if (busy) stuck++;
        end
        chk("t3_no_grant_while_full", 64'(stuck), 64'd0);
        wrusedw = 11'd1016;
      end
    join
    wait_idle();
    wrusedw = 11'd0;

    // Overlong, zero-length and early-terminated frames
    exp_frame(0, 3, 5, 64'h2_0000);
    send_frame(0, 3, 5, 64'h2_0000);
    wait_idle();
    exp_frame(0, 0, 1, 64'h3_0000);
    send_frame(0, 0, 1, 64'h3_0000);
    wait_idle();
    exp_frame(0, 4, 2, 64'h4_0000);
    send_frame(0, 4, 2, 64'h4_0000);
    wait_idle();
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd10);

    // Asynchronous reset on the second word of an 8-word frame
    exp_gnt.push_back(0);
    exp_wr.push_back(word(64'h5_0000, 0));
    len0 = 11'd8;
    req0 = 1'b1;
    wait_gnt(0, ok);
    req0 = 1'b0;
    vld0 = 1'b1;
    data0 = word(64'h5_0000, 0);
    @(negedge clk);
    data0 = word(64'h5_0000, 1);
    #2 aclr = 1'b1;
    #1 chk_reset_outputs("abort");
    vld0 = 1'b0;
    @(negedge clk);
    aclr = 1'b0;
    exp_frame(0, 2, 2, 64'h6_0000);
    exp_frame(1, 2, 2, 64'h7_0000);
    fork
      send_frame(0, 2, 2, 64'h6_0000);
      send_frame(1, 2, 2, 64'h7_0000);
    join
    wait_idle();

    // wrfull stall mid-frame
    exp_frame(0, 6, 6, 64'h8_0000);
    fork
      send_frame(0, 6, 6, 64'h8_0000);
      begin
        bit g;
        wait_gnt(0, g);
        @(posedge clk);
        @(posedge clk);
        #1 wrfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t6_rdy0_full", 64'(rdy0), 64'd0);
          if (i > 0) chk("t6_wrreq_full", 64'(wrreq), 64'd0);
        end
        @(posedge clk);
        #1 wrfull = 1'b0;
      end
    join
    wait_idle();

    repeat (4) @(negedge clk);
    chk("final_frame_cnt", 64'(frame_cnt), 64'd3);
    chk("left_gnt", 64'(exp_gnt.size()), 64'd0);
    chk("left_wr", 64'(exp_wr.size()), 64'd0);
    chk("left_err", 64'(exp_err.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
